// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the memory responder.
//   - RISC-V funct3 access-size codes (F3_*)
//   - FSM state encoding used by mem_responder
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: fetch and data request/response bundle between the core
// (master) and the memory responder (slave).
//   if_req/if_addr         -> fetch request, held until if_ready
//   if_ready/if_rdata      <- one-cycle fetch response
//   dm_req/we/funct3/addr/wdata -> data request, held until dm_ready
//   dm_ready/rdata/misalign     <- one-cycle data response
interface mem_responder_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        dm_misalign;

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
    input  if_ready, if_rdata,
    input  dm_ready, dm_rdata, dm_misalign
  );

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
    output if_ready, if_rdata,
    output dm_ready, dm_rdata, dm_misalign
  );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane logic.
//   Access side (request being issued to the array):
//     acc_funct3, acc_addr_lo, acc_wdata -> acc_be, acc_wdata_rep, acc_misalign
//   Response side (word read back from the array):
//     rsp_funct3, rsp_addr_lo, rsp_word  -> rsp_rdata (lane-selected, extended)
// The two sides take separate inputs because a store/misalign decision is made
// on the edge that enters RESP, while load extension happens during RESP from
// the latched request.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  acc_funct3,
  input  logic [1:0]  acc_addr_lo,
  input  logic [31:0] acc_wdata,
  output logic [3:0]  acc_be,
  output logic [31:0] acc_wdata_rep,
  output logic        acc_misalign,

  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_word,
  output logic [31:0] rsp_rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    acc_be        = 4'b0000;
    acc_wdata_rep = acc_wdata;
    case (acc_funct3)
      F3_B: begin
        acc_be        = 4'b0001 << acc_addr_lo;
        acc_wdata_rep = {4{acc_wdata[7:0]}};
      end
      F3_H: begin
        acc_be        = acc_addr_lo[1] ? 4'b1100 : 4'b0011;
        acc_wdata_rep = {2{acc_wdata[15:0]}};
      end
      F3_W: begin
        acc_be        = 4'b1111;
        acc_wdata_rep = acc_wdata;
      end
      default: begin
        acc_be        = 4'b0000;
        acc_wdata_rep = acc_wdata;
      end
    endcase
  end

  // Halfword sizes (signed or unsigned) need addr[0]=0; words need addr[1:0]=0.
  always_comb begin
    acc_misalign = 1'b0;
    if ((acc_funct3 == F3_H || acc_funct3 == F3_HU) && acc_addr_lo[0])
      acc_misalign = 1'b1;
    else if (acc_funct3 == F3_W && acc_addr_lo != 2'b00)
      acc_misalign = 1'b1;
  end

  always_comb begin
    byte_sel  = rsp_word[{rsp_addr_lo, 3'b000} +: 8];
    half_sel  = rsp_addr_lo[1] ? rsp_word[31:16] : rsp_word[15:0];
    rsp_rdata = rsp_word;
    case (rsp_funct3)
      F3_B:    rsp_rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rsp_rdata = {{16{half_sel[15]}}, half_sel};
      F3_BU:   rsp_rdata = {24'd0, byte_sel};
      F3_HU:   rsp_rdata = {16'd0, half_sel};
      default: rsp_rdata = rsp_word;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-ported word memory serving fetch and data requests
// behind a req/ready handshake with LAT wait states.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : mem_responder_if.slave (fetch + data request/response)
//   if_count, dm_count : ready-pulse counters, present only when the macro
//                        MEM_PERF_CNT_EN is defined
// Data requests win over fetches when both are pending in IDLE. Ready is
// asserted during RESP, which is entered LAT cycles after the accepting edge.
// Stores commit on the edge that enters RESP; loads read the array on that
// same edge and are extended during RESP. Outputs are zero outside RESP.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_responder_if.slave bus
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0] if_count,
  output logic [31:0] dm_count
`endif
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               is_dm_q, is_dm_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               misalign_q, misalign_d;

  logic               enter_resp;
  logic               wr_en;
  logic [ADDR_W-1:0]  idx_d;
  logic [3:0]         acc_be;
  logic [31:0]        acc_wdata_rep;
  logic               acc_misalign;
  logic [31:0]        rsp_rdata;
  logic               if_ready_w;
  logic               dm_ready_w;

  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        rd_word_q;

  // Address bits outside the word index are ignored by design.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.dm_addr[31:ADDR_W+2]};

  // Next-state and request latch. In IDLE the *_d fields carry the incoming
  // request so that LAT=0 can access the array on the accepting edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_dm_d = is_dm_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dm_req) begin
          is_dm_d = 1'b1;
          we_d    = bus.dm_we;
          f3_d    = bus.dm_funct3;
          addr_d  = bus.dm_addr[ADDR_W+1:0];
          wdata_d = bus.dm_wdata;
          cnt_d   = LAT_CNT;
          state_d = (LAT == 0) ? S_RESP : S_WAIT;
        end else if (bus.if_req) begin
          is_dm_d = 1'b0;
          we_d    = 1'b0;
          f3_d    = F3_W;
          addr_d  = {bus.if_addr[ADDR_W+1:2], 2'b00};
          wdata_d = '0;
          cnt_d   = LAT_CNT;
          state_d = (LAT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign idx_d      = addr_d[ADDR_W+1:2];

  mem_lane_align u_align (
    .acc_funct3    (f3_d),
    .acc_addr_lo   (addr_d[1:0]),
    .acc_wdata     (wdata_d),
    .acc_be        (acc_be),
    .acc_wdata_rep (acc_wdata_rep),
    .acc_misalign  (acc_misalign),
    .rsp_funct3    (f3_q),
    .rsp_addr_lo   (addr_q[1:0]),
    .rsp_word      (rd_word_q),
    .rsp_rdata     (rsp_rdata)
  );

  // Reset on the would-be commit edge abandons the store.
  assign wr_en = enter_resp && is_dm_d && we_d && !acc_misalign && !rst;

  always_comb begin
    misalign_d = misalign_q;
    if (enter_resp) misalign_d = is_dm_d && acc_misalign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_dm_q    <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= F3_W;
      addr_q     <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_dm_q    <= is_dm_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage: byte-enabled write and registered read, no reset so contents
  // survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem_q[idx_d][8*b +: 8] <= acc_wdata_rep[8*b +: 8];
      end
    end
    if (enter_resp) rd_word_q <= mem_q[idx_d];
  end

  assign if_ready_w      = (state_q == S_RESP) && !is_dm_q;
  assign dm_ready_w      = (state_q == S_RESP) && is_dm_q;
  assign bus.if_ready    = if_ready_w;
  assign bus.dm_ready    = dm_ready_w;
  assign bus.if_rdata    = if_ready_w ? rd_word_q : 32'd0;
  // Stores and rejected accesses return zero data.
  assign bus.dm_rdata    = (dm_ready_w && !we_q && !misalign_q) ? rsp_rdata : 32'd0;
  assign bus.dm_misalign = dm_ready_w && misalign_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] if_count_q, if_count_d;
  logic [31:0] dm_count_q, dm_count_d;

  always_comb begin
    if_count_d = if_count_q + {31'd0, if_ready_w};
    dm_count_d = dm_count_q + {31'd0, dm_ready_w};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_count_q <= '0;
      dm_count_q <= '0;
    end else begin
      if_count_q <= if_count_d;
      dm_count_q <= dm_count_d;
    end
  end

  assign if_count = if_count_q;
  assign dm_count = dm_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one LAT=1 instance (u_dut1) for function/priority/wrap
// checks and one LAT=3 instance (u_dut3) for reset during WAIT.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk;
  logic rst1;
  logic rst3;
  int   total;
  int   bad;
  int   exp_if1;
  int   exp_dm1;
  int   exp_dm3;

  mem_responder_if b1 ();
  mem_responder_if b3 ();

`ifdef MEM_PERF_CNT_EN
  logic [31:0] if_count1, dm_count1, if_count3, dm_count3;
`endif

  mem_responder #(.DEPTH(64), .ADDR_W(6), .LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1.slave)
`ifdef MEM_PERF_CNT_EN
    ,
    .if_count (if_count1),
    .dm_count (dm_count1)
`endif
  );

  mem_responder #(.DEPTH(64), .ADDR_W(6), .LAT(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3.slave)
`ifdef MEM_PERF_CNT_EN
    ,
    .if_count (if_count3),
    .dm_count (dm_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The two ready outputs of one instance must never be high together.
  always @(negedge clk) begin
    assert (!(b1.if_ready && b1.dm_ready)) else begin
      bad++;
      $error("FAIL both_ready1 observed=1 expected=0");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dm_op(input bit sel3, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic mis, output int lat);
    bit got;
    got = 0; lat = 0; rd = '0; mis = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (sel3) begin
      b3.dm_req = 1'b1; b3.dm_we = we; b3.dm_funct3 = f3; b3.dm_addr = addr; b3.dm_wdata = wd;
    end else begin
      b1.dm_req = 1'b1; b1.dm_we = we; b1.dm_funct3 = f3; b1.dm_addr = addr; b1.dm_wdata = wd;
    end
    while (!got && lat < 32) begin
      @(posedge clk); #1;
      lat++;
      if (sel3 ? b3.dm_ready : b1.dm_ready) begin
        got = 1;
        rd  = sel3 ? b3.dm_rdata : b1.dm_rdata;
        mis = sel3 ? b3.dm_misalign : b1.dm_misalign;
      end
    end
    if (sel3) b3.dm_req = 1'b0; else b1.dm_req = 1'b0;
    if (sel3) exp_dm3++; else exp_dm1++;
    check("dm_got", {31'd0, got}, 32'd1);
    $display("dm op u%0d we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h mis=%0d lat=%0d",
             sel3 ? 3 : 1, we, f3, addr, wd, rd, mis, lat);
  endtask

  task automatic if_op(input logic [31:0] addr, output logic [31:0] rd, output int lat);
    bit got;
    got = 0; lat = 0; rd = '0;
    @(posedge clk);
    @(negedge clk);
    b1.if_req = 1'b1; b1.if_addr = addr;
    while (!got && lat < 32) begin
      @(posedge clk); #1;
      lat++;
      if (b1.if_ready) begin got = 1; rd = b1.if_rdata; end
    end
    b1.if_req = 1'b0;
    exp_if1++;
    check("if_got", {31'd0, got}, 32'd1);
    $display("fetch addr=%h -> rdata=%h lat=%0d", addr, rd, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          dm_at, if_at, cyc;
    bit          seen;

    total = 0; bad = 0; exp_if1 = 0; exp_dm1 = 0; exp_dm3 = 0;
    rst1 = 1'b1; rst3 = 1'b1;
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_funct3 = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_funct3 = 0; b3.dm_addr = 0; b3.dm_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    // Reset state
    check("rst_if_ready", {31'd0, b1.if_ready}, 32'd0);
    check("rst_dm_ready", {31'd0, b1.dm_ready}, 32'd0);
    check("rst_dm_rdata", b1.dm_rdata, 32'd0);
    check("rst_if_rdata", b1.if_rdata, 32'd0);
    check("rst_misalign", {31'd0, b1.dm_misalign}, 32'd0);

    // SW then LW with latency LAT+1 = 2
    dm_op(0, 1, F3_W, 32'h10, 32'hDEADBEEF, rd, mis, lat);
    check("sw_lat", lat, 32'd2);
    check("sw_mis", {31'd0, mis}, 32'd0);
    dm_op(0, 0, F3_W, 32'h10, 32'h0, rd, mis, lat);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_lat", lat, 32'd2);

    // Byte store and extended loads
    dm_op(0, 1, F3_B, 32'h11, 32'h12345680, rd, mis, lat);
    dm_op(0, 0, F3_B, 32'h11, 32'h0, rd, mis, lat);
    check("lb", rd, 32'hFFFFFF80);
    dm_op(0, 0, F3_BU, 32'h11, 32'h0, rd, mis, lat);
    check("lbu", rd, 32'h00000080);
    dm_op(0, 0, F3_H, 32'h10, 32'h0, rd, mis, lat);
    check("lh", rd, 32'hFFFF80EF);
    dm_op(0, 0, F3_HU, 32'h12, 32'h0, rd, mis, lat);
    check("lhu_hi", rd, 32'h0000DEAD);

    // Halfword store to the upper lane
    dm_op(0, 1, F3_W, 32'h14, 32'h0, rd, mis, lat);
    dm_op(0, 1, F3_H, 32'h16, 32'hABCD1234, rd, mis, lat);
    dm_op(0, 0, F3_W, 32'h14, 32'h0, rd, mis, lat);
    check("sh_word", rd, 32'h12340000);
    dm_op(0, 0, F3_B, 32'h17, 32'h0, rd, mis, lat);
    check("lb_pos", rd, 32'h00000012);

    // Misalignment: rejected at normal latency, array untouched
    dm_op(0, 0, F3_W, 32'h12, 32'h0, rd, mis, lat);
    check("mis_lw_flag", {31'd0, mis}, 32'd1);
    check("mis_lw_data", rd, 32'd0);
    check("mis_lw_lat", lat, 32'd2);
    dm_op(0, 0, F3_H, 32'h13, 32'h0, rd, mis, lat);
    check("mis_lh_flag", {31'd0, mis}, 32'd1);
    dm_op(0, 1, F3_W, 32'h11, 32'hFFFFFFFF, rd, mis, lat);
    check("mis_sw_flag", {31'd0, mis}, 32'd1);
    dm_op(0, 1, 3'b011, 32'h10, 32'h0, rd, mis, lat);
    check("bad_f3_store_mis", {31'd0, mis}, 32'd0);
    dm_op(0, 0, 3'b011, 32'h10, 32'h0, rd, mis, lat);
    check("array_unchanged", rd, 32'hDEAD80EF);

    // Address wrap: 0x100 aliases word 0; fetch ignores addr[1:0]
    dm_op(0, 1, F3_W, 32'h100, 32'hCAFEF00D, rd, mis, lat);
    dm_op(0, 0, F3_W, 32'h0, 32'h0, rd, mis, lat);
    check("wrap_lw", rd, 32'hCAFEF00D);
    if_op(32'h103, rd, lat);
    check("fetch_data", rd, 32'hCAFEF00D);
    check("fetch_lat", lat, 32'd2);
    if_op(32'h10, rd, lat);
    check("fetch_data2", rd, 32'hDEAD80EF);

    // Simultaneous requests: data first, fetch accepted after return to IDLE
    @(posedge clk);
    @(negedge clk);
    b1.dm_req = 1; b1.dm_we = 0; b1.dm_funct3 = F3_W; b1.dm_addr = 32'h10;
    b1.if_req = 1; b1.if_addr = 32'h100;
    dm_at = 0; if_at = 0; cyc = 0;
    while (if_at == 0 && cyc < 32) begin
      @(posedge clk); #1;
      cyc++;
      if (b1.dm_ready) begin
        dm_at = cyc;
        check("prio_dm_data", b1.dm_rdata, 32'hDEAD80EF);
        b1.dm_req = 0;
      end
      if (b1.if_ready) begin
        if_at = cyc;
        check("prio_if_data", b1.if_rdata, 32'hCAFEF00D);
        b1.if_req = 0;
      end
    end
    b1.dm_req = 0; b1.if_req = 0;
    exp_dm1++; exp_if1++;
    check("prio_dm_cycle", dm_at, 32'd2);
    check("prio_if_cycle", if_at, 32'd5);
    $display("priority dm_ready@%0d if_ready@%0d", dm_at, if_at);

    // LAT=3 instance: normal store, then reset in second WAIT cycle
    dm_op(1, 1, F3_W, 32'h20, 32'h11111111, rd, mis, lat);
    check("lat3_sw_lat", lat, 32'd4);
    @(posedge clk);
    @(negedge clk);
    b3.dm_req = 1; b3.dm_we = 1; b3.dm_funct3 = F3_W; b3.dm_addr = 32'h20; b3.dm_wdata = 32'h22222222;
    seen = 0;
    @(posedge clk); #1; seen |= b3.dm_ready;  // accepted, first WAIT
    @(posedge clk); #1; seen |= b3.dm_ready;  // second WAIT
    @(negedge clk);
    rst3 = 1'b1; b3.dm_req = 0;
    @(posedge clk); #1; seen |= b3.dm_ready;
    @(negedge clk);
    rst3 = 1'b0;
    exp_dm3 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; seen |= b3.dm_ready;
    end
    check("lat3_abort_noready", {31'd0, seen}, 32'd0);
    $display("lat3 reset-in-wait ready_seen=%0d", seen);
    dm_op(1, 0, F3_W, 32'h20, 32'h0, rd, mis, lat);
    check("lat3_word_kept", rd, 32'h11111111);
    check("lat3_lw_lat", lat, 32'd4);

`ifdef MEM_PERF_CNT_EN
    check("if_count1", if_count1, exp_if1);
    check("dm_count1", dm_count1, exp_dm1);
    check("dm_count3", dm_count3, exp_dm3);
    check("if_count3", if_count3, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
